// File: rtl/mips_pipe_pkg.sv
`default_nettype none
//============================================================================
// Module      : mips_pipe_pkg
// Description : Shared types and constants for the MIPS pipeline controller.
// Revision    : 1.0 - initial release
//============================================================================
package mips_pipe_pkg;

    // EX operand source selection
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Fetch controller state
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT       = 2'd1,
        WAIT_REDIR = 2'd2
    } state_t;

    // Sequential fetch stride in bytes
    localparam int PC_INC = 4;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/mips_hazard_detect.sv
`default_nettype none
//============================================================================
// Module      : mips_hazard_detect
// Description : Combinational RAW / load-use hazard detection and EX
//               operand forwarding selects.
// Revision    : 1.0 - initial release
//============================================================================
module mips_hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    output logic              o_hazard,
    output fwd_sel_t          o_fwd_a,
    output fwd_sel_t          o_fwd_b
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_load_use;

    // A destination "hits" ID when it is non-zero and matches a source ID reads
    assign w_ex_hit   = (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    assign w_mem_hit  = (i_mem_rd != '0) &&
                        ((i_mem_rd == i_id_rs) || (i_id_uses_rt && (i_mem_rd == i_id_rt)));
    assign w_load_use = i_ex_mem_read && w_ex_hit;

    generate
        if (FWD_EN != 0) begin : g_fwd
            logic w_unused_fwd;
            // With forwarding only a load result is too late for the next EX
            assign w_unused_fwd = i_ex_reg_write ^ w_mem_hit;

            // Hazard flag and forwarding muxes; MEM is younger so it wins over WB
            always_comb begin
                o_hazard = w_load_use;
                o_fwd_a  = FWD_RF;
                o_fwd_b  = FWD_RF;
                if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs)) begin
                    o_fwd_a = FWD_MEM;
                end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs)) begin
                    o_fwd_a = FWD_WB;
                end
                if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rt)) begin
                    o_fwd_b = FWD_MEM;
                end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_ex_rt)) begin
                    o_fwd_b = FWD_WB;
                end
            end
        end else begin : g_no_fwd
            logic w_unused_nofwd;
            // Without forwarding the EX sources and WB are irrelevant: the
            // register file writes before it reads
            assign w_unused_nofwd = ^{i_ex_rs, i_ex_rt, i_wb_rd, i_wb_reg_write};

            // Stall on any in-flight producer of an ID source
            always_comb begin
                o_hazard = w_load_use ||
                           (i_ex_reg_write && w_ex_hit) ||
                           (i_mem_reg_write && w_mem_hit);
                o_fwd_a  = FWD_RF;
                o_fwd_b  = FWD_RF;
            end
        end
    endgenerate

endmodule : mips_hazard_detect
`default_nettype wire

// File: rtl/mips_pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module      : mips_pipe_ctrl
// Description : Five-stage MIPS pipeline controller: fetch PC, redirects,
//               hazard stalls, forwarding selects, memory-wait freeze and
//               saturating stall/flush counters.
// Revision    : 1.0 - initial release
//============================================================================
module mips_pipe_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FWD_EN   = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] EX_Rs,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic [REG_AW-1:0] EX_Rd,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] MEM_Rd,
    input  logic              MEM_RegWrite,
    input  logic [REG_AW-1:0] WB_Rd,
    input  logic              WB_RegWrite,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] BranchPC,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpPC,
    input  logic              Mem_Ready,
    output logic [ADDR_W-1:0] Out_PC,
    output logic              Pipe_En,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Flush,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              Misalign_Err,
    output logic [CNT_W-1:0]  Stall_Cnt,
    output logic [CNT_W-1:0]  Flush_Cnt
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              w_hazard;
    fwd_sel_t          w_fwd_a;
    fwd_sel_t          w_fwd_b;
    logic              w_redir;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic              w_apply;
    logic [ADDR_W-1:0] w_apply_tgt;
    logic              w_stall_ev;

    mips_hazard_detect #(
        .FWD_EN (FWD_EN),
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_id_rs         (ID_Rs),
        .i_id_rt         (ID_Rt),
        .i_id_uses_rt    (ID_UsesRt),
        .i_ex_rs         (EX_Rs),
        .i_ex_rt         (EX_Rt),
        .i_ex_rd         (EX_Rd),
        .i_ex_reg_write  (EX_RegWrite),
        .i_ex_mem_read   (EX_MemRead),
        .i_mem_rd        (MEM_Rd),
        .i_mem_reg_write (MEM_RegWrite),
        .i_wb_rd         (WB_Rd),
        .i_wb_reg_write  (WB_RegWrite),
        .o_hazard        (w_hazard),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    // Jump resolves in the same stage as a branch and has priority over it
    assign w_redir     = Jump | PCSrc;
    assign w_redir_tgt = Jump ? JumpPC : BranchPC;

    // Forwarding selects are forced to the register file while in reset
    assign FwdA = Reset_n ? w_fwd_a : FWD_RF;
    assign FwdB = Reset_n ? w_fwd_b : FWD_RF;

    assign Out_PC       = pc_q;
    assign Misalign_Err = misalign_q;
    assign Stall_Cnt    = stall_cnt_q;
    assign Flush_Cnt    = flush_cnt_q;

    // Next-state, next-PC and pipeline-control decode by cycle priority
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        misalign_d  = misalign_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        Pipe_En     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        w_apply     = 1'b0;
        w_apply_tgt = '0;
        w_stall_ev  = 1'b0;

        if (!Reset_n) begin
            Pipe_En    = 1'b0;
            IFID_Write = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (!Mem_Ready) begin
            // Whole pipe frozen; only the first redirect seen is remembered
            Pipe_En    = 1'b0;
            IFID_Write = 1'b0;
            w_stall_ev = 1'b1;
            case (state_q)
                WAIT_REDIR: state_d = WAIT_REDIR;
                default: begin
                    if (w_redir) begin
                        state_d  = WAIT_REDIR;
                        target_d = w_redir_tgt;
                    end else begin
                        state_d = WAIT;
                    end
                end
            endcase
        end else if (state_q == WAIT_REDIR) begin
            state_d     = RUN;
            w_apply     = 1'b1;
            w_apply_tgt = target_q;
        end else begin
            state_d = RUN;
            if (w_hazard) begin
                // Redirect is dropped; the branch stays in ID and retries
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
                w_stall_ev = 1'b1;
            end else if (w_redir) begin
                w_apply     = 1'b1;
                w_apply_tgt = w_redir_tgt;
            end else begin
                pc_d = pc_q + ADDR_W'(PC_INC);
            end
        end

        if (w_apply) begin
            pc_d       = {w_apply_tgt[ADDR_W-1:2], 2'b00};
            IFID_Flush = 1'b1;
            if (w_apply_tgt[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (!(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end

        if (w_stall_ev && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and PC registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule : mips_pipe_ctrl
`default_nettype wire

// File: tb/tb_mips_pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_mips_pipe_ctrl
// Description : Self-checking bench for mips_pipe_ctrl. Instance 0 uses
//               forwarding and default widths; instance 1 disables
//               forwarding and uses 4-bit counters to reach saturation.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mips_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic        pcsrc, jump, mem_ready;
    logic [31:0] branch_pc, jump_pc;

    logic [31:0] out_pc     [2];
    logic        pipe_en    [2];
    logic        ifid_write [2];
    logic        ifid_flush [2];
    logic        idex_flush [2];
    logic [1:0]  fwd_a      [2];
    logic [1:0]  fwd_b      [2];
    logic        mis        [2];
    logic [15:0] stall0, flush0;
    logic [3:0]  stall1, flush1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per instance
    logic [31:0] m_pc     [2];
    bit          m_pend   [2];
    logic [31:0] m_tgt    [2];
    bit          m_mis    [2];
    int          m_stall  [2];
    int          m_flush  [2];

    always #5 clk = ~clk;

    mips_pipe_ctrl #(.ADDR_W(32), .REG_AW(5), .RESET_PC(32'h0), .FWD_EN(1), .CNT_W(16)) dut (
        .Clk(clk), .Reset_n(reset_n),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
        .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_Rd(ex_rd),
        .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread),
        .MEM_Rd(mem_rd), .MEM_RegWrite(mem_regwrite),
        .WB_Rd(wb_rd), .WB_RegWrite(wb_regwrite),
        .PCSrc(pcsrc), .BranchPC(branch_pc), .Jump(jump), .JumpPC(jump_pc),
        .Mem_Ready(mem_ready),
        .Out_PC(out_pc[0]), .Pipe_En(pipe_en[0]), .IFID_Write(ifid_write[0]),
        .IFID_Flush(ifid_flush[0]), .IDEX_Flush(idex_flush[0]),
        .FwdA(fwd_a[0]), .FwdB(fwd_b[0]), .Misalign_Err(mis[0]),
        .Stall_Cnt(stall0), .Flush_Cnt(flush0)
    );

    mips_pipe_ctrl #(.ADDR_W(32), .REG_AW(5), .RESET_PC(32'h0), .FWD_EN(0), .CNT_W(4)) dut_nf (
        .Clk(clk), .Reset_n(reset_n),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
        .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_Rd(ex_rd),
        .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread),
        .MEM_Rd(mem_rd), .MEM_RegWrite(mem_regwrite),
        .WB_Rd(wb_rd), .WB_RegWrite(wb_regwrite),
        .PCSrc(pcsrc), .BranchPC(branch_pc), .Jump(jump), .JumpPC(jump_pc),
        .Mem_Ready(mem_ready),
        .Out_PC(out_pc[1]), .Pipe_En(pipe_en[1]), .IFID_Write(ifid_write[1]),
        .IFID_Flush(ifid_flush[1]), .IDEX_Flush(idex_flush[1]),
        .FwdA(fwd_a[1]), .FwdB(fwd_b[1]), .Misalign_Err(mis[1]),
        .Stall_Cnt(stall1), .Flush_Cnt(flush1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    // A source register is blocked if an in-flight non-zero writer targets it
    function automatic bit reads_reg(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic bit m_hazard(input int k);
        if (ex_memread && reads_reg(ex_rd)) return 1'b1;
        if (k == 1) begin
            if (ex_regwrite && reads_reg(ex_rd)) return 1'b1;
            if (mem_regwrite && reads_reg(mem_rd)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(input int k, input logic [4:0] src);
        if (k == 1 || !reset_n) return 2'b00;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
        if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_comb(input int k);
        logic [3:0] e; // {Pipe_En, IFID_Write, IFID_Flush, IDEX_Flush}
        if (!reset_n)            e = 4'b0011;
        else if (!mem_ready)     e = 4'b0000;
        else if (m_pend[k])      e = 4'b1110;
        else if (m_hazard(k))    e = 4'b1001;
        else if (jump || pcsrc)  e = 4'b1110;
        else                     e = 4'b1100;
        chk($sformatf("pipe_en%0d", k), pipe_en[k], e[3]);
        chk($sformatf("ifid_write%0d", k), ifid_write[k], e[2]);
        chk($sformatf("ifid_flush%0d", k), ifid_flush[k], e[1]);
        chk($sformatf("idex_flush%0d", k), idex_flush[k], e[0]);
        chk($sformatf("fwd_a%0d", k), fwd_a[k], m_fwd(k, ex_rs));
        chk($sformatf("fwd_b%0d", k), fwd_b[k], m_fwd(k, ex_rt));
    endtask

    task automatic m_apply(input int k, input logic [31:0] t);
        m_pc[k] = t & 32'hFFFF_FFFC;
        if (t[1:0] != 2'b00) m_mis[k] = 1'b1;
        if (m_flush[k] < cnt_max(k)) m_flush[k]++;
    endtask

    task automatic model_update(input int k);
        logic [31:0] t;
        t = jump ? jump_pc : branch_pc;
        if (!reset_n) begin
            m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_tgt[k] = 32'h0;
            m_mis[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
        end else if (!mem_ready) begin
            if (m_stall[k] < cnt_max(k)) m_stall[k]++;
            if ((jump || pcsrc) && !m_pend[k]) begin
                m_pend[k] = 1'b1;
                m_tgt[k]  = t;
            end
        end else if (m_pend[k]) begin
            m_apply(k, m_tgt[k]);
            m_pend[k] = 1'b0;
        end else if (m_hazard(k)) begin
            if (m_stall[k] < cnt_max(k)) m_stall[k]++;
        end else if (jump || pcsrc) begin
            m_apply(k, t);
        end else begin
            m_pc[k] = m_pc[k] + 32'd4;
        end
    endtask

    task automatic check_regs(input int k);
        chk($sformatf("out_pc%0d", k), out_pc[k], m_pc[k]);
        chk($sformatf("misalign%0d", k), mis[k], m_mis[k]);
        chk($sformatf("stall_cnt%0d", k), (k == 0) ? 64'(stall0) : 64'(stall1), 64'(m_stall[k]));
        chk($sformatf("flush_cnt%0d", k), (k == 0) ? 64'(flush0) : 64'(flush1), 64'(m_flush[k]));
    endtask

    // One clock: combinational check mid-cycle, then registered check after the edge
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) check_comb(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
        for (int k = 0; k < 2; k++) check_regs(k);
    endtask

    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; branch_pc = 32'h0; jump_pc = 32'h0;
        mem_ready = 1'b1;
    endtask

    initial begin
        int s0;
        logic [31:0] p0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_tgt[k] = 32'h0;
            m_mis[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
        end
        quiet();
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset and sequential fetch
        step(); step();
        chk("rst_pc", out_pc[0], 32'h0);
        chk("rst_stall", stall0, 16'd0);
        chk("rst_flush", flush0, 16'd0);
        reset_n = 1'b1;
        step(); chk("seq_pc4", out_pc[0], 32'h4);
        step(); chk("seq_pc8", out_pc[0], 32'h8);

        // Load-use costs a single stall; register 0 never stalls
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_ifid_write", ifid_write[0], 1'b0);
        chk("lu_idex_flush", idex_flush[0], 1'b1);
        step();
        chk("lu_pc_hold", out_pc[0], 32'h8);
        chk("lu_stall", stall0, 16'd1);
        id_rs = 5'd0;
        #1;
        chk("lu_r0_ifid_write", ifid_write[0], 1'b1);
        step();
        chk("lu_r0_pc", out_pc[0], 32'hC);
        quiet();

        // Forwarding precedence MEM over WB
        mem_rd = 5'd3; wb_rd = 5'd3; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd3;
        #1; chk("fwd_mem", fwd_a[0], 2'b10);
        step();
        mem_regwrite = 1'b0;
        #1; chk("fwd_wb", fwd_a[0], 2'b01);
        step();
        quiet();

        // Redirect: jump beats branch, target alignment forced
        jump = 1'b1; jump_pc = 32'h40; pcsrc = 1'b1; branch_pc = 32'h80;
        #1; chk("redir_ifid_flush", ifid_flush[0], 1'b1);
        step();
        chk("redir_pc", out_pc[0], 32'h40);
        chk("redir_flush_cnt", flush0, 16'd1);
        pcsrc = 1'b0; jump_pc = 32'h42;
        step();
        chk("misalign_pc", out_pc[0], 32'h40);
        chk("misalign_err", mis[0], 1'b1);
        quiet();

        // Memory wait with a branch arriving mid-wait
        s0 = int'(stall0); p0 = out_pc[0];
        mem_ready = 1'b0;
        #1; chk("mw_pipe_en", pipe_en[0], 1'b0);
        step();
        pcsrc = 1'b1; branch_pc = 32'h100;
        step();
        pcsrc = 1'b0;
        step();
        chk("mw_pc_hold", out_pc[0], p0);
        chk("mw_stall", stall0, 16'(s0 + 3));
        mem_ready = 1'b1;
        step();
        chk("mw_redir_pc", out_pc[0], 32'h100);
        quiet();

        // No forwarding: a pending MEM write to Rt stalls
        mem_regwrite = 1'b1; mem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; ex_rt = 5'd7;
        #1;
        chk("nf_ifid_write", ifid_write[1], 1'b0);
        chk("nf_idex_flush", idex_flush[1], 1'b1);
        chk("nf_fwd_b", fwd_b[1], 2'b00);
        chk("fw_no_stall", ifid_write[0], 1'b1);
        step();
        quiet();

        // Reset during a wait drops the latched redirect
        mem_ready = 1'b0; jump = 1'b1; jump_pc = 32'h200;
        step();
        jump = 1'b0; reset_n = 1'b0;
        step();
        reset_n = 1'b1; mem_ready = 1'b1;
        step();
        chk("rst_wait_pc", out_pc[0], 32'h4);
        quiet();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n      = ($urandom_range(0, 149) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_rd       = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 4) != 0);
            jump         = ($urandom_range(0, 7) == 0);
            pcsrc        = ($urandom_range(0, 7) == 0);
            jump_pc      = $urandom;
            branch_pc    = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_pipe_ctrl
`default_nettype wire

// File: doc/mips_pipe_ctrl.md
# mips_pipe_ctrl

Central pipeline controller for the five-stage MIPS core (IF/ID/EX/MEM/WB). It owns the fetch PC register and applies jump and branch redirects. It also detects RAW and load-use hazards, generates EX forwarding selects, and freezes the pipeline while data memory is not ready. It is parametrised in address width, register-address width and forwarding mode, and keeps stall and flush performance counters.

## Interface
Parameters:
- ADDR_W, 32, PC and target width
- REG_AW, 5, register-address width
- RESET_PC, 0, PC value loaded at reset
- FWD_EN, 1, 1 = EX forwarding; 0 = stall on every RAW hazard
- CNT_W, 16, performance-counter width

Ports (Clk rising edge, reset synchronous active-low):
- Clk  in  1  core clock
- Reset_n  in  1  synchronous active-low reset
- ID_Rs, ID_Rt  in  REG_AW  source registers of the instruction in ID
- ID_UsesRt  in  1  instruction in ID reads Rt
- EX_Rs, EX_Rt  in  REG_AW  source registers of the instruction in EX
- EX_Rd  in  REG_AW  destination register in EX
- EX_RegWrite, EX_MemRead  in  1  EX writes a register / EX is a load
- MEM_Rd  in  REG_AW  destination register in MEM
- MEM_RegWrite  in  1  MEM writes a register
- WB_Rd  in  REG_AW  destination register in WB
- WB_RegWrite  in  1  WB writes a register
- PCSrc  in  1  taken branch resolved in ID
- BranchPC  in  ADDR_W  branch target
- Jump  in  1  jump in ID
- JumpPC  in  ADDR_W  jump target
- Mem_Ready  in  1  data memory can complete its access this cycle
- Out_PC  out  ADDR_W  current fetch address (registered)
- Pipe_En  out  1  all pipeline registers may advance
- IFID_Write  out  1  IF/ID register loads
- IFID_Flush  out  1  IF/ID register loads a bubble
- IDEX_Flush  out  1  ID/EX register loads a bubble
- FwdA, FwdB  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM
- Misalign_Err  out  1  sticky; set when a redirect target is misaligned
- Stall_Cnt, Flush_Cnt  out  CNT_W  saturating performance counters

## Operation
- Register 0 never causes a hazard and is never forwarded.
- Load-use hazard: EX_MemRead, EX_Rd≠0, and EX_Rd equals ID_Rs or (ID_UsesRt and ID_Rt).
- When FWD_EN=0, a RAW hazard is also detected against MEM_Rd/MEM_RegWrite, and against EX_Rd/EX_RegWrite without a load. The register file writes before it reads, so WB never causes a hazard.
- Priority for each cycle, highest first:
  1. Memory wait (Mem_Ready=0): Pipe_En=0 and PC holds.
  2. Hazard: PC holds, IFID_Write=0, IDEX_Flush=1. Any redirect in the same cycle is ignored; it is re-evaluated next cycle.
  3. Redirect: Jump takes precedence over PCSrc. PC loads the target with bits [1:0] forced to 0, and IFID_Flush=1.
  4. Otherwise PC advances by 4, wrapping modulo 2^ADDR_W.
- Redirect during a memory wait: a redirect asserted while Mem_Ready=0 latches its target (Jump wins). The latched target is applied on the first cycle Mem_Ready=1, with IFID_Flush=1.
- FSM states:
  - RUN: Mem_Ready=0 → WAIT, or → WAIT_REDIR if a redirect is present.
  - WAIT: redirect → WAIT_REDIR; Mem_Ready=1 → RUN.
  - WAIT_REDIR: Mem_Ready=1 → RUN and apply the latched target. Further redirects are ignored (the first one is kept).
- Forwarding (FWD_EN=1): FwdA=10 if MEM_RegWrite, MEM_Rd≠0 and MEM_Rd==EX_Rs; else 01 on the same test against WB; else 00. MEM takes precedence over WB. FwdB applies the same rule to EX_Rt. When FWD_EN=0, FwdA and FwdB are tied to 00.
- Misalign_Err sets when an applied target has bits [1:0]≠0. It clears only on reset.
- Stall_Cnt increments on every cycle with a memory wait or a hazard. Flush_Cnt increments on every applied redirect. Both saturate at all-ones.

## Timing
- Reset (Reset_n=0 sampled at a Clk edge):
  - Out_PC=RESET_PC, FSM=RUN, latched target cleared, Misalign_Err=0, counters=0.
  - While Reset_n=0: Pipe_En=0, IFID_Flush=1, IDEX_Flush=1, IFID_Write=0, FwdA=FwdB=00.
  - A reset asserted mid-wait discards any latched redirect.
- Pipe_En, IFID_Write, IFID_Flush, IDEX_Flush and FwdA/FwdB are combinational from the inputs and the FSM state, with zero-cycle latency.
- Out_PC and the counters update on the Clk rising edge. A redirect is visible on Out_PC one cycle after PCSrc or Jump is sampled.
- A load-use hazard costs exactly one stall cycle.

## Structure
- Package mips_pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - state_t enum: RUN, WAIT, WAIT_REDIR
  - PC_INC=4
- Sub-module mips_hazard_detect, combinational: produces the hazard flag and FwdA/FwdB, and takes FWD_EN and REG_AW as parameters.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles, then release → Out_PC=0, then 4, 8, 12 on successive cycles; counters=0.
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs=5 → one cycle with IFID_Write=0 and IDEX_Flush=1, PC holds at 8, Stall_Cnt=1. Repeat with ID_Rs=0 → no stall.
- Forwarding (FWD_EN=1): MEM_Rd=WB_Rd=3, both RegWrite=1, EX_Rs=3 → FwdA=10. With MEM_RegWrite=0 → FwdA=01.
- Redirect: Jump=1 to 0x40 together with PCSrc=1 to 0x80 → Out_PC=0x40 next cycle, IFID_Flush=1, Flush_Cnt=1. Jump to 0x42 → Out_PC=0x40 and Misalign_Err=1.
- Memory wait: Mem_Ready=0 for 3 cycles with PCSrc=1 to 0x100 in the second cycle → Pipe_En=0 and PC holds throughout. PC becomes 0x100 one cycle after Mem_Ready returns; Stall_Cnt advances by 3.
- FWD_EN=0: MEM_RegWrite=1, MEM_Rd=7, ID_Rt=7 with ID_UsesRt=1 → stall cycle; FwdB stays 00.
